// File: rtl/popcount_accum.sv
// rtl/popcount_accum.sv - accumulates the number of 1-bits over a group of words
//
// Purpose: each accepted word is counted CHUNK bits per cycle into a
// saturating running total; the total is presented once the word flagged
// in_last has been counted, and cleared when the consumer accepts it.
//
// Ports:
//   clk        in   1      rising-edge clock for all state
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      in_data/in_last valid
//   in_ready   out  1      block can accept a word (IDLE)
//   in_data    in   WIDTH  word whose 1-bits are counted
//   in_last    in   1      word is the last of its group
//   out_valid  out  1      out_count/out_sat valid (DONE)
//   out_ready  in   1      consumer accepts the result
//   out_count  out  ACC_W  running total of 1-bits in the group
//   out_sat    out  1      the group total was clamped at its maximum

module popcount_accum #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_count,
   output logic             out_sat
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_q, last_d;
   logic [ACC_W-1:0] total_q, total_d;
   logic             sat_q, sat_d;

   // One extra bit on the adder exposes the carry that triggers clamping.
   logic [ACC_W:0]   chunk_pc;
   logic [ACC_W:0]   sum_w;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         total_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         total_q <= total_d;
         sat_q   <= sat_d;
      end
   end

   // Next-state logic for the FSM and the counting datapath.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      total_d = total_q;
      sat_d   = sat_q;

      chunk_pc = '0;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_pc = chunk_pc + {{ACC_W{1'b0}}, shift_q[i]};
      end
      sum_w = {1'b0, total_q} + chunk_pc;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               shift_d = in_data;
               last_d  = in_last;
               cnt_d   = '0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            shift_d = shift_q >> CHUNK;
            cnt_d   = cnt_q + CW'(1);
            if (sum_w[ACC_W]) begin
               total_d = '1;
               sat_d   = 1'b1;
            end else begin
               total_d = sum_w[ACC_W-1:0];
            end
            // A non-last word returns to IDLE keeping the total for the group.
            if (cnt_q == LAST_CNT) begin
               state_d = last_q ? DONE : IDLE;
            end
         end
         DONE: begin
            if (out_ready) begin
               total_d = '0;
               sat_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode directly from registered state.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      out_count = total_q;
      out_sat   = sat_q;
   end

endmodule

// File: tb/tb_popcount_accum.sv
// tb/tb_popcount_accum.sv - self-checking bench for popcount_accum

module tb_popcount_accum;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // default instance: WIDTH 8, CHUNK 2, ACC_W 16
   logic        in_valid = 0, in_last = 0, out_ready = 0;
   logic [7:0]  in_data = '0;
   logic        in_ready, out_valid, out_sat;
   logic [15:0] out_count;

   // narrow accumulator instance: ACC_W 4
   logic        a_in_valid = 0, a_in_last = 0, a_out_ready = 0;
   logic [7:0]  a_in_data = '0;
   logic        a_in_ready, a_out_valid, a_out_sat;
   logic [3:0]  a_out_count;

   // wide word instance: WIDTH 12, CHUNK 3
   logic        b_in_valid = 0, b_in_last = 0, b_out_ready = 0;
   logic [11:0] b_in_data = '0;
   logic        b_in_ready, b_out_valid, b_out_sat;
   logic [15:0] b_out_count;

   popcount_accum dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_sat(out_sat)
   );

   popcount_accum #(.WIDTH(8), .CHUNK(2), .ACC_W(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count), .out_sat(a_out_sat)
   );

   popcount_accum #(.WIDTH(12), .CHUNK(3), .ACC_W(16)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count), .out_sat(b_out_sat)
   );

   // Stimulus helpers (drive only; callers compare).
   task automatic send8(input logic [7:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      in_valid = 1; in_data = d; in_last = l;
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_out8(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
   endtask

   task automatic accept8();
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   task automatic send_a(input logic [7:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
      a_in_valid = 1; a_in_data = d; a_in_last = l;
      @(negedge clk);
      a_in_valid = 0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 16'd0 || out_sat !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut8: rdy=%b ov=%b cnt=%0d sat=%b, want 1 0 0 0", in_ready, out_valid, out_count, out_sat);
      end
      n_checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_dut_a: rdy=%b ov=%b cnt=%0d, want 1 0 0", a_in_ready, a_out_valid, a_out_count);
      end
      n_checks++;
      if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_dut_b: rdy=%b ov=%b cnt=%0d, want 1 0 0", b_in_ready, b_out_valid, b_out_count);
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_single_latency();
      int busy_bad = 0;
      @(negedge clk);
      in_valid = 1; in_data = 8'hB5; in_last = 1;   // cycle 0
      @(negedge clk);
      in_valid = 0;
      for (int c = 1; c <= 4; c++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
         @(negedge clk);
      end
      n_checks++;
      if (busy_bad != 0) begin
         n_fail++;
         $display("FAIL single_busy: %0d cycles of 1..4 had in_ready/out_valid wrong, want 0", busy_bad);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 16'd5 || out_sat !== 1'b0) begin
         n_fail++;
         $display("FAIL single_b5: cycle5 ov=%b cnt=%0d sat=%b, want 1 5 0", out_valid, out_count, out_sat);
      end
      accept8();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 16'd0) begin
         n_fail++;
         $display("FAIL single_accept: ov=%b rdy=%b cnt=%0d, want 0 1 0", out_valid, in_ready, out_count);
      end
   endtask

   task automatic test_group();
      logic [7:0] words [3];
      int seen_ov = 0;
      int cyc;
      words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h0F;
      for (int w = 0; w < 3; w++) begin
         send8(words[w], w == 2);
         if (w < 2) begin
            for (int k = 0; k < 8; k++) begin
               if (out_valid) seen_ov++;
               @(negedge clk);
            end
         end
      end
      n_checks++;
      if (seen_ov != 0) begin
         n_fail++;
         $display("FAIL group_between: out_valid high %0d cycles between words, want 0", seen_ov);
      end
      wait_out8(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 16'd12 || out_sat !== 1'b0) begin
         n_fail++;
         $display("FAIL group_12: ov=%b cnt=%0d sat=%b, want 1 12 0", out_valid, out_count, out_sat);
      end
      accept8();
   endtask

   task automatic test_edges();
      int cyc;
      send8(8'h00, 1);
      wait_out8(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 16'd0) begin
         n_fail++;
         $display("FAIL zero_word: ov=%b cnt=%0d, want 1 0", out_valid, out_count);
      end
      accept8();
      send8(8'hFF, 1);
      wait_out8(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 16'd8) begin
         n_fail++;
         $display("FAIL ones_word: ov=%b cnt=%0d, want 1 8", out_valid, out_count);
      end
      accept8();
   endtask

   task automatic test_backpressure();
      int cyc;
      int bad = 0;
      send8(8'hA7, 1);
      wait_out8(cyc);
      in_valid = 1; in_data = 8'hFF; in_last = 1;
      for (int k = 0; k < 10; k++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 16'd5) bad++;
         @(negedge clk);
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL hold: %0d of 10 held cycles wrong (cnt=%0d), want 0", bad, out_count);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 16'd0) begin
         n_fail++;
         $display("FAIL hold_release: rdy=%b ov=%b cnt=%0d, want 1 0 0", in_ready, out_valid, out_count);
      end
      @(negedge clk);
      in_valid = 0;
      wait_out8(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 16'd8) begin
         n_fail++;
         $display("FAIL after_hold: ov=%b cnt=%0d, want 1 8", out_valid, out_count);
      end
      accept8();
   endtask

   task automatic test_reset_mid_count();
      int cyc;
      @(negedge clk);
      in_valid = 1; in_data = 8'hFF; in_last = 1;   // cycle 0
      @(negedge clk);
      in_valid = 0;                                  // cycle 1
      @(negedge clk);                                // cycle 2
      rst = 1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_async: rdy=%b ov=%b cnt=%0d, want 1 0 0", in_ready, out_valid, out_count);
      end
      @(negedge clk);
      rst = 0;
      send8(8'h03, 1);
      wait_out8(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 16'd2 || out_sat !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_fresh: ov=%b cnt=%0d sat=%b, want 1 2 0", out_valid, out_count, out_sat);
      end
      accept8();
   endtask

   task automatic test_saturate();
      int n;
      for (int w = 0; w < 3; w++) send_a(8'hFF, w == 2);
      n = 0;
      while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_count !== 4'd15 || a_out_sat !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_group: ov=%b cnt=%0d sat=%b, want 1 15 1", a_out_valid, a_out_count, a_out_sat);
      end
      a_out_ready = 1;
      @(negedge clk);
      a_out_ready = 0;
      send_a(8'h01, 1);
      n = 0;
      while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_count !== 4'd1 || a_out_sat !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_next: ov=%b cnt=%0d sat=%b, want 1 1 0", a_out_valid, a_out_count, a_out_sat);
      end
      a_out_ready = 1;
      @(negedge clk);
      a_out_ready = 0;
   endtask

   task automatic test_wide();
      int first = -1;
      @(negedge clk);
      b_in_valid = 1; b_in_data = 12'hFFF; b_in_last = 1;   // cycle 0
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         b_in_valid = 0;
         if (b_out_valid && first < 0) first = c;
      end
      n_checks++;
      if (first != 5 || b_out_count !== 16'd12) begin
         n_fail++;
         $display("FAIL wide12: out_valid at cycle %0d cnt=%0d, want 5 12", first, b_out_count);
      end
      b_out_ready = 1;
      @(negedge clk);
      b_out_ready = 0;
   endtask

   task automatic test_random();
      int cyc, len, exp_total;
      logic [7:0] w;
      for (int g = 0; g < 20; g++) begin
         len = $urandom_range(1, 4);
         exp_total = 0;
         for (int k = 0; k < len; k++) begin
            w = 8'($urandom);
            exp_total += $countones(w);
            send8(w, k == len - 1);
         end
         if (exp_total > 65535) exp_total = 65535;
         wait_out8(cyc);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_count !== 16'(exp_total) || out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL random_g%0d: ov=%b cnt=%0d sat=%b, want 1 %0d 0", g, out_valid, out_count, out_sat, exp_total);
         end
         accept8();
      end
   endtask

   initial begin
      test_reset();
      test_single_latency();
      test_group();
      test_edges();
      test_backpressure();
      test_reset_mid_count();
      test_saturate();
      test_wide();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
